group3_quad_encoder: RTL and testbench
======================================

# group3_quad_encoder

Quadrature A/B signal generator: the transmit-side counterpart of the team's Hall decoder. It accepts step commands (direction, edge count, edge period) over a valid/ready handshake and emits Hall_A/Hall_B edges in the same phase order the decoder counts. It mirrors the decoder's position (0..347) and cycle count so benches and the position-control loop can check decoder tracking against ground truth.

## Interface
- COUNTS_PER_REV, 348: position modulus; pos wraps at COUNTS_PER_REV-1.
- MIN_PERIOD, 2: smallest permitted edge period in clocks; smaller commanded periods are clamped to this value.

- clk_48  input  1  system clock; all logic on rising edge.
- reset  input  1  asynchronous, active-high reset.
- cmd_valid  input  1  command offered.
- cmd_ready  output  1  block idle and able to accept a command.
- cmd_dir  input  1  1 = forward (decoder "add"), 0 = reverse.
- cmd_steps  input  12  number of quadrature edges to emit.
- cmd_period  input  20  clocks between edges.
- abort  input  1  cancels the running command.
- Hall_A  output  1  quadrature phase A.
- Hall_B  output  1  quadrature phase B.
- dir  output  1  direction of the current or last command.
- pos  output  12  mirrored position, 0..COUNTS_PER_REV-1.
- cyc  output  4  mirrored revolution count, modulo 16.
- busy  output  1  command in progress.
- done  output  1  one-cycle pulse when a command completes normally.
- Hall_Z  output  1  index pulse; only present with GROUP3_QENC_INDEX_EN.

## Operation
- Forward sequence of (Hall_A,Hall_B): 00→01→11→10→00. Reverse is the exact inverse. Exactly one phase changes per edge.
- FSM states:
  - IDLE: cmd_ready=1. On cmd_valid&&cmd_ready, latch dir, the step count, and the period (clamped to at least MIN_PERIOD).
    - steps==0: go to DONE.
    - Otherwise: clear the 20-bit timer and go to RUN.
  - RUN: timer increments each clock. When timer==period−1, emit one edge, update pos/cyc, decrement remaining steps, and clear the timer.
    - If the edge was the last one, go to DONE.
  - DONE: assert done for one cycle, then go to IDLE.
  - abort in RUN: go to IDLE next cycle. No edge is emitted that cycle, the phase outputs hold their current level, and done is not pulsed.
    - abort in IDLE or DONE has no effect.
- pos/cyc update per edge:
  - Forward: pos+1. From COUNTS_PER_REV−1, pos→0 and cyc+1 (15→0 wraps).
  - Reverse: pos−1. From 0, pos→COUNTS_PER_REV−1 and cyc−1 (0→15 wraps).
- Hall_A/Hall_B, pos, cyc, Hall_A/B phase, dir, busy and done are all registered; no combinational path from inputs to them.
- Phase state, pos and cyc persist across commands; only reset clears them.

## Timing
- Reset values:
  - Hall_A=0, Hall_B=0, pos=0, cyc=0, dir=0, busy=0, done=0, cmd_ready=0, Hall_Z=0.
  - cmd_ready rises on the first clock after reset deasserts.
- Reset asserted mid-command: all outputs return to reset values immediately; the command is lost.
- Command accepted at edge T:
  - busy=1 and cmd_ready=0 from T+1.
  - First phase edge visible at T+period; subsequent edges every period clocks.
- Last edge visible at cycle L. done=1 at L+1, busy=0 and cmd_ready=1 at L+2.
- steps==0 accepted at T: done=1 at T+1, cmd_ready=1 at T+2, no edge emitted.
- Command presented while busy is not accepted; cmd_valid must be held until the handshake completes.
- abort sampled at edge A: busy=0 and cmd_ready=1 from A+1.
  - If abort coincides with a scheduled edge, abort wins and that edge is not emitted.
- Edge rate ≤ clk_48/MIN_PERIOD.

## Configuration
- GROUP3_QENC_INDEX_EN defined:
  - Hall_Z port exists.
  - Hall_Z pulses high for exactly one clock, in the same cycle the edge is visible, whenever pos wraps in either direction (COUNTS_PER_REV−1→0 forward, 0→COUNTS_PER_REV−1 reverse).
- Undefined: no Hall_Z port and no index logic; all other behaviour is identical.

## Test plan
- Reset, then forward with steps=4, period=10 accepted at T → edges at T+10, T+20, T+30, T+40. Phase sequence 01,11,10,00; pos=4; done at T+41.
- From pos=0/cyc=0, reverse with steps=1, period=2 → phase 10, pos=347, cyc=15. Hall_Z pulses once when the macro is defined.
- Forward with steps=349, period=1 → period clamped to 2; edges every 2 clocks; final pos=1, cyc=1. The team's decoder, connected to Hall_A/Hall_B, reports pos=1, cyc=1.
- steps=0 → done one cycle after acceptance; Hall_A/Hall_B unchanged; no busy-to-edge activity.
- Forward with steps=100, period=5, abort after the 7th edge → no further edges, pos=7, done never pulses, cmd_ready=1 the next cycle.
- Reset asserted mid-command at pos=20 → Hall_A/Hall_B, pos, cyc and busy all 0 asynchronously; the next command is accepted normally.

Source files
------------

// File: rtl/group3_quad_encoder.sv
// Quadrature A/B generator: runs step commands (dir, edges, period) into Hall_A/Hall_B edges.
// Ports: clk_48/reset, cmd_* handshake, abort; Hall_A/B, dir, pos, cyc, busy, done; Hall_Z iff GROUP3_QENC_INDEX_EN.
module group3_quad_encoder #(
  parameter int COUNTS_PER_REV = 348,
  parameter int MIN_PERIOD     = 2
) (
  input  logic        clk_48,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_dir,
  input  logic [11:0] cmd_steps,
  input  logic [19:0] cmd_period,
  input  logic        abort,
  output logic        Hall_A,
  output logic        Hall_B,
  output logic        dir,
  output logic [11:0] pos,
  output logic [3:0]  cyc,
  output logic        busy,
  output logic        done
`ifdef GROUP3_QENC_INDEX_EN
  ,
  output logic        Hall_Z
`endif
);

  localparam logic [11:0] LP_MAXPOS = 12'(COUNTS_PER_REV - 1);
  localparam logic [19:0] LP_MINPER = 20'(MIN_PERIOD);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t      r_state, w_state_nxt;
  logic [19:0] r_timer, w_timer_nxt;
  logic [19:0] r_period, w_period_nxt;
  logic [11:0] r_steps, w_steps_nxt;
  logic [11:0] r_pos, w_pos_nxt;
  logic [3:0]  r_cyc, w_cyc_nxt;
  logic [1:0]  r_ab, w_ab_nxt;
  logic        r_dir, w_dir_nxt;
  logic        r_ready, w_ready_nxt;
  logic        r_busy, w_busy_nxt;
  logic        r_done, w_done_nxt;
  logic        w_edge;

  // Abort beats a coincident scheduled edge.
  assign w_edge = (r_state == S_RUN) && !abort &&
                  (r_timer == r_period - 20'd1);

  always_comb begin
    w_state_nxt  = r_state;
    w_timer_nxt  = r_timer;
    w_period_nxt = r_period;
    w_steps_nxt  = r_steps;
    w_pos_nxt    = r_pos;
    w_cyc_nxt    = r_cyc;
    w_ab_nxt     = r_ab;
    w_dir_nxt    = r_dir;
    w_ready_nxt  = 1'b0;
    w_busy_nxt   = 1'b0;
    w_done_nxt   = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        w_ready_nxt = 1'b1;
        if (cmd_valid && r_ready) begin
          w_ready_nxt  = 1'b0;
          w_busy_nxt   = 1'b1;
          w_dir_nxt    = cmd_dir;
          w_steps_nxt  = cmd_steps;
          w_period_nxt = (cmd_period < LP_MINPER) ? LP_MINPER
                                                  : cmd_period;
          w_timer_nxt  = '0;
          w_state_nxt  = (cmd_steps == 12'd0) ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        if (abort) begin
          w_ready_nxt = 1'b1;
          w_state_nxt = S_IDLE;
        end else begin
          w_busy_nxt = 1'b1;
          if (w_edge) begin
            w_timer_nxt = '0;
            w_steps_nxt = r_steps - 12'd1;
            unique case (r_ab)
              2'b00: w_ab_nxt = r_dir ? 2'b01 : 2'b10;
              2'b01: w_ab_nxt = r_dir ? 2'b11 : 2'b00;
              2'b11: w_ab_nxt = r_dir ? 2'b10 : 2'b01;
              2'b10: w_ab_nxt = r_dir ? 2'b00 : 2'b11;
            endcase
            if (r_dir) begin
              if (r_pos == LP_MAXPOS) begin
                w_pos_nxt = '0;
                w_cyc_nxt = r_cyc + 4'd1;
              end else begin
                w_pos_nxt = r_pos + 12'd1;
              end
            end else begin
              if (r_pos == 12'd0) begin
                w_pos_nxt = LP_MAXPOS;
                w_cyc_nxt = r_cyc - 4'd1;
              end else begin
                w_pos_nxt = r_pos - 12'd1;
              end
            end
            if (r_steps == 12'd1) w_state_nxt = S_DONE;
          end else begin
            w_timer_nxt = r_timer + 20'd1;
          end
        end
      end
      S_DONE: begin
        w_busy_nxt  = 1'b1;
        w_done_nxt  = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_48 or posedge reset) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_timer  <= '0;
      r_period <= '0;
      r_steps  <= '0;
      r_pos    <= '0;
      r_cyc    <= '0;
      r_ab     <= '0;
      r_dir    <= 1'b0;
      r_ready  <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_timer  <= w_timer_nxt;
      r_period <= w_period_nxt;
      r_steps  <= w_steps_nxt;
      r_pos    <= w_pos_nxt;
      r_cyc    <= w_cyc_nxt;
      r_ab     <= w_ab_nxt;
      r_dir    <= w_dir_nxt;
      r_ready  <= w_ready_nxt;
      r_busy   <= w_busy_nxt;
      r_done   <= w_done_nxt;
    end
  end

`ifdef GROUP3_QENC_INDEX_EN
  logic r_z;
  logic w_wrap;

  assign w_wrap = w_edge &&
                  (r_dir ? (r_pos == LP_MAXPOS) : (r_pos == 12'd0));

  always_ff @(posedge clk_48 or posedge reset) begin
    if (reset) r_z <= 1'b0;
    else       r_z <= w_wrap;
  end

  assign Hall_Z = r_z;
`endif

  assign cmd_ready = r_ready;
  assign Hall_A    = r_ab[1];
  assign Hall_B    = r_ab[0];
  assign dir       = r_dir;
  assign pos       = r_pos;
  assign cyc       = r_cyc;
  assign busy      = r_busy;
  assign done      = r_done;

endmodule

// File: tb/tb_group3_quad_encoder.sv
// Bench for group3_quad_encoder: schedule-based model checked every cycle
// plus directed vectors with hand-computed expectations.
module tb_group3_quad_encoder;

  logic        clk_48 = 1'b0;
  logic        reset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_dir;
  logic [11:0] cmd_steps;
  logic [19:0] cmd_period;
  logic        abort;
  logic        Hall_A, Hall_B, dir, busy, done;
  logic [11:0] pos;
  logic [3:0]  cyc;
`ifdef GROUP3_QENC_INDEX_EN
  logic        Hall_Z;
`endif

  group3_quad_encoder dut (
    .clk_48    (clk_48),
    .reset     (reset),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_dir   (cmd_dir),
    .cmd_steps (cmd_steps),
    .cmd_period(cmd_period),
    .abort     (abort),
    .Hall_A    (Hall_A),
    .Hall_B    (Hall_B),
    .dir       (dir),
    .pos       (pos),
    .cyc       (cyc),
    .busy      (busy),
    .done      (done)
`ifdef GROUP3_QENC_INDEX_EN
    ,
    .Hall_Z    (Hall_Z)
`endif
  );

  always #5 clk_48 = ~clk_48;

  int n_chk  = 0;
  int n_fail = 0;
  bit chk_en = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int pmod(input int a, input int m);
    int r;
    r = a % m;
    return (r < 0) ? r + m : r;
  endfunction

  // Quadrature level for a net signed edge count.
  function automatic int ab_of(input int t);
    case (pmod(t, 4))
      0:       return 0;
      1:       return 1;
      2:       return 3;
      default: return 2;
    endcase
  endfunction

  // Model: each command is a schedule of edge times; position is the
  // net signed edge count reduced modulo the revolution.
  int n = 0, st = 0, lend = 0, per = 2, free_at = 0, done_at = -1;
  int total = 0;
  bit running = 0, post_rst = 1, ev_edge = 0;
  bit m_dir = 0, m_ready = 0, m_busy = 0, m_done = 0, m_z = 0;

  always @(posedge clk_48 or posedge reset) begin
    if (reset) begin
      running = 0; total = 0; m_dir = 0;
      m_ready = 0; m_busy = 0; m_done = 0; m_z = 0;
      post_rst = 1; done_at = -1; st = n; free_at = 32'h7fffffff;
    end else begin
      n++;
      ev_edge = 0;
      if (post_rst) begin
        post_rst = 0;
        free_at = n;
      end
      if (running && n > st) begin
        if (abort) begin
          running = 0; free_at = n; done_at = -1;
        end else if ((n - st) % per == 0) begin
          total += m_dir ? 1 : -1;
          ev_edge = 1;
          if (n == lend) running = 0;
        end
      end
      if (cmd_valid && m_ready) begin
        st = n;
        m_dir = cmd_dir;
        per = (cmd_period < 20'd2) ? 2 : int'(cmd_period);
        if (cmd_steps == 12'd0) begin
          done_at = n + 1; free_at = n + 2;
        end else begin
          running = 1;
          lend = n + per * int'(cmd_steps);
          done_at = lend + 1; free_at = lend + 2;
        end
      end
      m_ready = (n >= free_at);
      m_busy  = (n >= st) && (n < free_at);
      m_done  = (n == done_at);
      m_z = ev_edge && ((m_dir && pmod(total, 348) == 0) ||
                        (!m_dir && pmod(total, 348) == 347));
    end
  end

  // Reference decoder watching the DUT phases.
  int dec_total = 0;
  int prev_ab = 0;
  int done_cnt = 0;

  always @(negedge clk_48) begin
    int cur;
    cur = int'({Hall_A, Hall_B});
    if (done === 1'b1) done_cnt++;
    if (reset) begin
      dec_total = 0;
    end else if (cur != prev_ab) begin
      if (cur == ab_of(pmod(dec_total, 4) + 1)) dec_total++;
      else if (cur == ab_of(pmod(dec_total, 4) - 1)) dec_total--;
      else chk("dec_illegal", cur, prev_ab);
    end
    prev_ab = cur;
    if (chk_en) begin
      chk("cmp_ab",    cur,             ab_of(total));
      chk("cmp_pos",   int'(pos),       pmod(total, 348));
      chk("cmp_cyc",   int'(cyc),
          pmod((total - pmod(total, 348)) / 348, 16));
      chk("cmp_dir",   int'(dir),       int'(m_dir));
      chk("cmp_ready", int'(cmd_ready), int'(m_ready));
      chk("cmp_busy",  int'(busy),      int'(m_busy));
      chk("cmp_done",  int'(done),      int'(m_done));
`ifdef GROUP3_QENC_INDEX_EN
      chk("cmp_z",     int'(Hall_Z),    int'(m_z));
`endif
    end
  end

  task automatic send(input bit d, input int s, input int p);
    bit ok;
    ok = 0;
    cmd_dir = d;
    cmd_steps = 12'(s);
    cmd_period = 20'(p);
    cmd_valid = 1'b1;
    for (int i = 0; i < 100; i++) begin
      if (cmd_ready === 1'b1) begin
        ok = 1;
        break;
      end
      @(negedge clk_48);
    end
    chk("send_accept", int'(ok), 1);
    if (ok) begin
      @(posedge clk_48);
      @(negedge clk_48);
    end
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle(input int lim);
    bit ok;
    ok = 0;
    for (int i = 0; i < lim; i++) begin
      @(negedge clk_48);
      if (busy === 1'b0 && cmd_ready === 1'b1) begin
        ok = 1;
        break;
      end
    end
    chk("idle_wait", int'(ok), 1);
  endtask

  task automatic reset_pulse();
    @(negedge clk_48);
    #2 reset = 1'b1;
    repeat (2) @(negedge clk_48);
    #2 reset = 1'b0;
    @(negedge clk_48);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int ph1 [4];
    int d0;
    ph1 = '{1, 3, 2, 0};
    reset = 1'b1;
    cmd_valid = 1'b0;
    cmd_dir = 1'b0;
    cmd_steps = '0;
    cmd_period = '0;
    abort = 1'b0;
    repeat (3) @(negedge clk_48);
    chk("rst_ready", int'(cmd_ready), 0);
    chk("rst_pos",   int'(pos), 0);
    chk("rst_ab",    int'({Hall_A, Hall_B}), 0);
    chk("rst_busy",  int'(busy), 0);
    reset = 1'b0;
    chk_en = 1;
    @(negedge clk_48);
    chk("rst_ready_rise", int'(cmd_ready), 1);

    // forward 4 edges, period 10
    send(1'b1, 4, 10);
    chk("t1_busy", int'(busy), 1);
    for (int k = 0; k < 4; k++) begin
      repeat (9) @(negedge clk_48);
      chk("t1_hold", int'({Hall_A, Hall_B}), (k == 0) ? 0 : ph1[k-1]);
      @(negedge clk_48);
      chk("t1_edge", int'({Hall_A, Hall_B}), ph1[k]);
    end
    chk("t1_pos", int'(pos), 4);
    @(negedge clk_48);
    chk("t1_done", int'(done), 1);
    @(negedge clk_48);
    chk("t1_idle", int'({busy, cmd_ready}), 1);

    // reverse one edge through the wrap
    reset_pulse();
    send(1'b0, 1, 2);
    @(negedge clk_48);
    chk("t2_hold", int'({Hall_A, Hall_B}), 0);
    @(negedge clk_48);
    chk("t2_ab",  int'({Hall_A, Hall_B}), 2);
    chk("t2_pos", int'(pos), 347);
    chk("t2_cyc", int'(cyc), 15);
`ifdef GROUP3_QENC_INDEX_EN
    chk("t2_z_on", int'(Hall_Z), 1);
`endif
    @(negedge clk_48);
`ifdef GROUP3_QENC_INDEX_EN
    chk("t2_z_off", int'(Hall_Z), 0);
`endif
    chk("t2_done", int'(done), 1);

    // period clamp, a full revolution plus one
    reset_pulse();
    send(1'b1, 349, 1);
    @(negedge clk_48);
    chk("t3_hold", int'({Hall_A, Hall_B}), 0);
    @(negedge clk_48);
    chk("t3_edge", int'({Hall_A, Hall_B}), 1);
    wait_idle(1000);
    chk("t3_pos", int'(pos), 1);
    chk("t3_cyc", int'(cyc), 1);
    chk("t3_dec_pos", pmod(dec_total, 348), 1);
    chk("t3_dec_cyc", pmod((dec_total - pmod(dec_total, 348)) / 348, 16), 1);

    // abort while idle is ignored, then a zero-step command
    abort = 1'b1;
    @(negedge clk_48);
    abort = 1'b0;
    send(1'b1, 0, 7);
    @(negedge clk_48);
    chk("t4_done", int'(done), 1);
    chk("t4_ab",   int'({Hall_A, Hall_B}), 1);
    @(negedge clk_48);
    chk("t4_idle", int'({busy, cmd_ready}), 1);
    chk("t4_pos",  int'(pos), 1);

    // abort after the 7th edge
    reset_pulse();
    send(1'b1, 100, 5);
    d0 = done_cnt;
    repeat (35) @(negedge clk_48);
    chk("t5_pre", int'(pos), 7);
    abort = 1'b1;
    @(negedge clk_48);
    abort = 1'b0;
    chk("t5_idle", int'({busy, cmd_ready}), 1);
    repeat (20) @(negedge clk_48);
    chk("t5_pos", int'(pos), 7);
    chk("t5_nodone", done_cnt - d0, 0);

    // abort on the cycle of a scheduled edge
    send(1'b1, 10, 4);
    repeat (7) @(negedge clk_48);
    abort = 1'b1;
    @(negedge clk_48);
    abort = 1'b0;
    repeat (10) @(negedge clk_48);
    chk("t5b_pos", int'(pos), 8);

    // reset mid-command at pos 20
    send(1'b1, 100, 2);
    repeat (24) @(negedge clk_48);
    chk("t6_pre", int'(pos), 20);
    #2 reset = 1'b1;
    #1;
    chk("t6_ab",   int'({Hall_A, Hall_B}), 0);
    chk("t6_pos",  int'(pos), 0);
    chk("t6_cyc",  int'(cyc), 0);
    chk("t6_busy", int'(busy), 0);
    chk("t6_rdy",  int'(cmd_ready), 0);
    repeat (2) @(negedge clk_48);
    #2 reset = 1'b0;
    @(negedge clk_48);
    send(1'b1, 3, 3);
    wait_idle(50);
    chk("t6_post", int'(pos), 3);

    repeat (3) @(negedge clk_48);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
